div_seq_param: RTL and testbench
================================

// Module: div_seq_param
// PURPOSE
//  Parametrised multi-cycle restoring divider: DW-bit dividend / VW-bit divisor -> DW-bit quotient, VW-bit remainder.
//  Adds signed/unsigned mode, divide-by-zero and signed-overflow flags, restart on start and reset of all outputs.
//  Sits beside the ALU as the long-latency divide unit; issued by the pipeline controller via start/ready.
// PARAMETERS
//  DW  32  dividend/quotient width; DW >= 2
//  VW  16  divisor/remainder width; 2 <= VW <= DW
//  (derived localparam CW = $clog2(DW+1), counter width)
// PORTS
//  clk    in   1   clock, rising edge
//  clrn   in   1   asynchronous reset, active-low
//  start  in   1   load a/b/sgn and begin; sampled every edge
//  sgn    in   1   1 = two's-complement signed divide, 0 = unsigned
//  a      in   DW  dividend
//  b      in   VW  divisor
//  q      out  DW  quotient (valid while ready=1)
//  r      out  VW  remainder (valid while ready=1)
//  busy   out  1   operation in progress
//  ready  out  1   result valid; held until next start
//  dz     out  1   divide-by-zero flag, valid with ready
//  ovf    out  1   signed overflow flag, valid with ready
//  count  out  CW  iteration counter
// BEHAVIOUR
//  Reset (clrn=0, any time incl. mid-operation): state=IDLE; busy=0, ready=0, q=0, r=0, dz=0, ovf=0, count=0.
//  States: IDLE, RUN, FIX, DONE.
//  start=1 in ANY state (priority over all else): latch sgn, sign bits sa=sgn&a[DW-1], sb=sgn&b[VW-1];
//   load magnitudes |a|, |b| (unsigned when sgn=0); reg_r=0; count=0; busy=1; ready=0; dz=0; ovf=0.
//   If b==0: next state FIX with dz path; else next state RUN. Aborts any in-flight divide.
//  RUN, one quotient bit per cycle, MSB first: sub = {reg_r, reg_q[DW-1]} - {1'b0, reg_b} (VW+1 bits).
//   sub[VW]=1 -> restore: reg_r = {reg_r[VW-2:0], reg_q[DW-1]}; else reg_r = sub[VW-1:0].
//   reg_q = {reg_q[DW-2:0], ~sub[VW]}; count++. When count == DW-1: -> FIX.
//  FIX, 1 cycle: q = (sa^sb) ? -reg_q : reg_q; r = sa ? -reg_r : reg_r (remainder takes dividend sign);
//   ovf = sgn & ~(sa^sb) & (reg_q == 2^(DW-1)) (q wraps to most-negative value); busy=0; ready=1; -> DONE.
//   dz path: q = all ones, r = a[VW-1:0] as loaded (raw, not magnitude), dz=1, ovf=0; busy=0; ready=1; -> DONE.
//  DONE: hold q, r, dz, ovf, ready=1 until start or reset; count holds DW.
//  Latency: start sampled at edge 0 -> ready=1 after edge DW+1 (normal), after edge 1 (b==0).
//  busy=1 exactly from after edge 0 until after the ready edge; busy and ready never both 1.
//  q/r change only in FIX and reset; intermediate values stay internal.
//  Unsigned: no overflow possible; ovf always 0.
// TESTING (DW=32, VW=16)
//  unsigned 100/7 -> q=14, r=2, dz=0, ovf=0; ready rises exactly 33 cycles after start edge.
//  signed -100/7 -> q=0xFFFFFFF2, r=0xFFFE; signed 100/-7 -> q=0xFFFFFFF2, r=0x0002.
//  a=0x12345678, b=0, either mode -> dz=1, q=0xFFFFFFFF, r=0x5678, ready after 1 cycle.
//  signed 0x80000000/0xFFFF -> q=0x80000000, r=0, ovf=1; unsigned same operands -> q=0x00008000, r=0x8000, ovf=0.
//  start 1000/10 then start 77/5 at cycle 10 -> first discarded; q=15, r=2, ready 33 cycles after second start.
//  clrn low at cycle 12 of a divide -> all outputs 0 immediately; no ready until a new start.

Source files
------------

// File: rtl/div_seq_param_if.sv
// div_seq_param_if: start/result bundle between the pipeline controller and the sequential divider
//   master (controller): drives start, sgn, a, b; observes q, r, busy, ready, dz, ovf, count
//   slave  (divider)   : the reverse
interface div_seq_param_if #(
  parameter int DW = 32,
  parameter int VW = 16
);
  localparam int CW = $clog2(DW + 1);
  logic          start;
  logic          sgn;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          busy;
  logic          ready;
  logic          dz;
  logic          ovf;
  logic [CW-1:0] count;
  modport master (output start, sgn, a, b, input q, r, busy, ready, dz, ovf, count);
  modport slave  (input start, sgn, a, b, output q, r, busy, ready, dz, ovf, count);
endinterface

// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle restoring divider, DW-bit dividend / VW-bit divisor, signed or unsigned
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset, clears state and every output
//   bus  : slave side of div_seq_param_if
//          start/sgn/a/b in; q/r result, busy, ready, dz (divide by zero), ovf (signed overflow), count out
module div_seq_param #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic              clk,
  input  logic              clrn,
  div_seq_param_if.slave    bus
);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]    r_state;
  logic          r_sgn, r_sa, r_sb;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_rem, r_b, r_araw;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_qo;
  logic [VW-1:0] r_ro;
  logic          r_busy, r_ready, r_dz, r_ovf;
  logic          w_sa, w_sb, w_zero, w_ovf;
  logic [DW-1:0] w_amag, w_qf;
  logic [VW-1:0] w_bmag, w_rf;
  logic [VW:0]   w_sub;
  assign w_sa   = bus.sgn & bus.a[DW-1];
  assign w_sb   = bus.sgn & bus.b[VW-1];
  assign w_amag = w_sa ? -bus.a : bus.a;
  assign w_bmag = w_sb ? -bus.b : bus.b;
  // trial subtract of the divisor from the partial remainder shifted by the next dividend bit
  assign w_sub  = {r_rem, r_q[DW-1]} - {1'b0, r_b};
  // a zero divisor has a zero magnitude, so the loaded magnitude doubles as the divide-by-zero tag
  assign w_zero = (r_b == '0);
  assign w_qf   = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_rf   = r_sa ? -r_rem : r_rem;
  // like-signed operands can only give +2^(DW-1), which wraps to the most negative quotient
  assign w_ovf  = r_sgn & ~(r_sa ^ r_sb) & (r_q == {1'b1, {(DW-1){1'b0}}});
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_sgn   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_q     <= '0;
      r_rem   <= '0;
      r_b     <= '0;
      r_araw  <= '0;
      r_cnt   <= '0;
      r_qo    <= '0;
      r_ro    <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.start) begin
      r_state <= (bus.b == '0) ? S_FIX : S_RUN;
      r_sgn   <= bus.sgn;
      r_sa    <= w_sa;
      r_sb    <= w_sb;
      r_q     <= w_amag;
      r_b     <= w_bmag;
      r_araw  <= bus.a[VW-1:0];
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_rem   <= w_sub[VW] ? {r_rem[VW-2:0], r_q[DW-1]} : w_sub[VW-1:0];
          r_q     <= {r_q[DW-2:0], ~w_sub[VW]};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == LAST) ? S_FIX : S_RUN;
        end
        S_FIX: begin
          r_qo    <= w_zero ? '1 : w_qf;
          r_ro    <= w_zero ? r_araw : w_rf;
          r_dz    <= w_zero;
          r_ovf   <= ~w_zero & w_ovf;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_DONE;
        end
        default: ;
      endcase
    end
  end
  assign bus.q     = r_qo;
  assign bus.r     = r_ro;
  assign bus.busy  = r_busy;
  assign bus.ready = r_ready;
  assign bus.dz    = r_dz;
  assign bus.ovf   = r_ovf;
  assign bus.count = r_cnt;
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: directed and random divides checked cycle by cycle against an arithmetic model
module tb_div_seq_param;
  localparam int DW = 32;
  localparam int VW = 16;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;
  div_seq_param_if #(.DW(DW), .VW(VW)) bus ();
  div_seq_param #(.DW(DW), .VW(VW)) dut (.clk(clk), .clrn(clrn), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // expected result straight from integer division; SV truncates toward zero and the
  // remainder follows the dividend, which is exactly the required signed behaviour
  task automatic model(input logic s, input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] q, output logic [15:0] r,
                       output logic dz, output logic ovf, output int lat);
    longint sa, sb, qq, rr;
    if (b == 16'h0) begin
      q = 32'hFFFF_FFFF; r = a[15:0]; dz = 1'b1; ovf = 1'b0; lat = 1;
    end else if (!s) begin
      q = a / 32'(b); r = 16'(a % 32'(b)); dz = 1'b0; ovf = 1'b0; lat = DW + 1;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0]; r = rr[15:0]; dz = 1'b0; ovf = (qq == 64'sd2147483648); lat = DW + 1;
    end
  endtask
  logic act = 1'b0;
  int k = 0;
  int exp_lat = 0;
  logic [31:0] eq, sq = '0;
  logic [15:0] er, sr = '0;
  logic edz, eovf, rdy;
  always @(posedge clk) begin
    #1;
    if (!clrn) begin
      act = 1'b0; sq = '0; sr = '0;
    end else if (bus.start) begin
      model(bus.sgn, bus.a, bus.b, eq, er, edz, eovf, exp_lat);
      act = 1'b1; k = 0;
    end else if (act && k < 1000) k++;
    if (act && k == exp_lat) begin
      sq = eq; sr = er;
    end
    rdy = act && (k >= exp_lat);
    check("busy", bus.busy, act && (k < exp_lat));
    check("ready", bus.ready, rdy);
    check("q", bus.q, sq);
    check("r", bus.r, sr);
    check("dz", bus.dz, rdy ? edz : 1'b0);
    check("ovf", bus.ovf, rdy ? eovf : 1'b0);
    if (!act) check("count idle", bus.count, 0);
    else if (!edz) check("count", bus.count, (k < DW) ? k : DW);
  end
  task automatic go(input logic s, input logic [31:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.sgn = s; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.sgn = 1'($urandom); bus.a = $urandom; bus.b = 16'($urandom);
    lat = 0;
    while (!bus.ready && lat < 60) begin
      @(posedge clk);
      #2;
      lat++;
    end
    if (!bus.ready) check("ready timeout", bus.ready, 1'b1);
  endtask
  task automatic res(input string name, input int lat, input int elat, input logic [31:0] q,
                     input logic [15:0] r, input logic dz, input logic ovf);
    check({name, " lat"}, lat, elat);
    check({name, " q"}, bus.q, q);
    check({name, " r"}, bus.r, r);
    check({name, " dz"}, bus.dz, dz);
    check({name, " ovf"}, bus.ovf, ovf);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, sel, gap;
    logic s;
    logic [31:0] a;
    logic [15:0] b;
    bus.start = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst busy", bus.busy, 1'b0);
    check("rst ready", bus.ready, 1'b0);
    check("rst q", bus.q, 0);
    clrn = 1'b1;
    go(1'b0, 32'd100, 16'd7, lat);
    res("u100/7", lat, 33, 32'd14, 16'd2, 1'b0, 1'b0);
    check("u100/7 count", bus.count, 32);
    go(1'b1, -32'sd100, 16'd7, lat);
    res("s-100/7", lat, 33, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0);
    go(1'b1, 32'd100, 16'hFFF9, lat);
    res("s100/-7", lat, 33, 32'hFFFF_FFF2, 16'h0002, 1'b0, 1'b0);
    go(1'b0, 32'h1234_5678, 16'h0, lat);
    res("u/0", lat, 1, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0);
    go(1'b1, 32'h1234_5678, 16'h0, lat);
    res("s/0", lat, 1, 32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0);
    go(1'b1, 32'h8000_0000, 16'hFFFF, lat);
    res("s min/-1", lat, 33, 32'h8000_0000, 16'h0, 1'b0, 1'b1);
    go(1'b0, 32'h8000_0000, 16'hFFFF, lat);
    res("u 2^31/ffff", lat, 33, 32'h0000_8000, 16'h8000, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.sgn = 1'b0; bus.a = 32'd1000; bus.b = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    go(1'b0, 32'd77, 16'd5, lat);
    res("restart", lat, 33, 32'd15, 16'd2, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.sgn = 1'b0; bus.a = 32'd1000; bus.b = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    check("arst busy", bus.busy, 1'b0);
    check("arst ready", bus.ready, 1'b0);
    check("arst q", bus.q, 0);
    check("arst r", bus.r, 0);
    check("arst dz", bus.dz, 1'b0);
    check("arst ovf", bus.ovf, 1'b0);
    check("arst count", bus.count, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (40) @(posedge clk);
    #2 check("no ready after reset", bus.ready, 1'b0);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 7);
      s = 1'($urandom);
      a = (sel == 3) ? 32'($urandom_range(0, 1000)) : $urandom;
      b = 16'($urandom);
      if (sel == 0) b = 16'h0;
      if (sel == 1) begin a = 32'h8000_0000; b = 16'hFFFF; end
      if (sel == 2) b = $urandom_range(0, 1) ? 16'h0001 : 16'hFFFF;
      if (sel == 4) b = 16'h8000;
      @(negedge clk);
      bus.start = 1'b1; bus.sgn = s; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0; bus.sgn = 1'($urandom); bus.a = $urandom; bus.b = 16'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(32, 40);
      repeat (gap) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
